// File: rtl/wr_arbiter.sv
// ----------------------------------------------------------------------------
// wr_arbiter
//   Shares the single FIFO write port among NUM_REQ producers in the write
//   clock domain. Bursts are granted in round-robin order. During a burst the
//   owner's beats are accepted whenever the FIFO is not full, and the owner's
//   data is muxed onto the memory write bus.
//
// Ports
//   wclk      : write-domain clock, rising edge
//   wrst_n    : asynchronous active-low reset
//   req       : per-requester "valid beat present"
//   last      : per-requester "current beat ends the burst"
//   wdata_in  : packed requester data, requester i on [i*DATA_WIDTH +: DATA_WIDTH]
//   full      : FIFO full flag (registered upstream, so no combinational loop)
//   w_en      : write enable to the pointer handler / memory
//   wdata     : owner's data to the memory write port
//   grant     : one-hot, grant[i] = requester i's beat accepted this cycle
//   owner_id  : current or most recent burst owner
//   busy      : high while a burst is in progress
// ----------------------------------------------------------------------------
module wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [ID_W-1:0]               owner_id,
    output logic                          busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  next_ptr;
    logic             accept;
    logic             end_burst;

    // Round-robin pick: scan offsets from high to low so the smallest offset
    // from rr_ptr with an active request is the final assignment.
    always_comb begin
        winner = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            logic [ID_W:0] sum;
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (req[sum[ID_W-1:0]])
                winner = sum[ID_W-1:0];
        end
    end

    assign next_ptr  = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);

    // full gates the write in the same cycle; a stalled owner keeps the port.
    assign accept    = (state == BURST) & req[owner] & ~full;

    // A burst also closes when the owner withdraws its request, so a silent
    // requester cannot hold the port indefinitely.
    assign end_burst = (accept & (last[owner] | (beat_cnt == CNT_W'(MAX_BURST - 1))))
                     | ~req[owner];

    assign w_en      = accept;
    assign grant     = accept ? (NUM_REQ'(1) << owner) : '0;
    assign wdata     = wdata_in[owner*DATA_WIDTH +: DATA_WIDTH];
    assign owner_id  = owner;
    assign busy      = (state == BURST);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= winner;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (end_burst) begin
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wr_arbiter
//   Bench for wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4). A reference
//   model tracks "is a burst open, who owns it, how many beats it has taken,
//   whose turn is next" as plain integers and predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N*DW-1:0] wdata_in;
    logic          full;
    logic          w_en;
    logic [DW-1:0] wdata;
    logic [N-1:0]  grant;
    logic [1:0]    owner_id;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_busy  = 0;
    int m_owner = 0;
    int m_next  = 0;
    int m_beats = 0;

    int wr_obs  = 0;
    int gq[$];

    wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last),
        .wdata_in(wdata_in), .full(full), .w_en(w_en), .wdata(wdata),
        .grant(grant), .owner_id(owner_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    function automatic logic [DW-1:0] slice(input int i);
        return wdata_in[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0;
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic tick();
        int acc;
        #1;
        acc = (m_busy != 0 && req[m_owner] && !full) ? 1 : 0;
        chk("busy",     32'(busy),     32'(m_busy));
        chk("owner_id", 32'(owner_id), 32'(m_owner));
        chk("w_en",     32'(w_en),     32'(acc));
        chk("grant",    32'(grant),    acc ? (32'(1) << m_owner) : 32'(0));
        chk("wdata",    32'(wdata),    32'(slice(m_owner)));
        if (grant != 0) gq.push_back(onehot_idx(grant));
        if (w_en) wr_obs++;
        @(posedge wclk);
        if (m_busy == 0) begin
            if (req != 0) begin
                m_owner = rr_pick(m_next, req);
                m_beats = 0;
                m_busy  = 1;
            end
        end else begin
            if (acc != 0) m_beats++;
            if ((acc != 0 && (last[m_owner] || m_beats == MB)) || !req[m_owner]) begin
                m_busy  = 0;
                m_next  = (m_owner + 1) % N;
                m_beats = 0;
            end
        end
        #1;
    endtask

    initial begin
        int w0, base, seen_busy, fifo_cnt;

        // ---------------- reset held with all requests active
        wrst_n = 1'b0; req = '1; last = '0; full = 1'b0;
        wdata_in = 32'h44_33_22_11;
        #64;
        chk("rst_w_en", 32'(w_en), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner_id), 0);
        chk("rst_wdata", 32'(wdata), 32'h11);
        @(posedge wclk); #1;
        wrst_n = 1'b1; req = '0;
        model_reset();
        tick();

        // ---------------- single requester, last on third beat
        w0 = wr_obs;
        req = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            wdata_in = $urandom;
            last = (m_busy != 0 && m_beats == 2) ? 4'b0100 : 4'b0000;
            if (m_beats == 0 && m_busy == 0 && c > 2) req = '0;
            tick();
        end
        req = '0; last = '0;
        tick();
        chk("single_wen_count", 32'(wr_obs - w0), 3);
        chk("single_idle", 32'(busy), 0);

        // ---------------- round-robin, all requesting, pointer now at 3
        gq.delete();
        req = 4'b1111;
        tick();
        chk("rr_after_single", 32'(owner_id), 3);
        for (int c = 0; c < 26; c++) begin
            wdata_in = $urandom;
            tick();
        end
        chk("rr_len", 32'(gq.size() >= 20), 1);
        for (int k = 0; k < 20 && k < gq.size(); k++)
            chk("rr_order", 32'(gq[k]), 32'((3 + k / 4) % 4));

        // ---------------- asynchronous reset mid-burst
        if (!busy) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_w_en", 32'(w_en), 0);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_owner", 32'(owner_id), 0);
        @(posedge wclk); #1;
        wrst_n = 1'b1; req = '0;
        model_reset();
        tick();

        // ---------------- full stall inside owner 1's burst after beat 2
        w0 = wr_obs; seen_busy = 0;
        req = 4'b0010;
        for (int c = 0; c < 30; c++) begin
            wdata_in = $urandom;
            if (m_busy != 0) seen_busy = 1;
            if (seen_busy != 0 && m_busy == 0) break;
            if (m_busy != 0 && m_beats == 2 && c < 4) begin
                full = 1'b1;
                for (int s = 0; s < 5; s++) tick();
                chk("stall_beats_held", 32'(m_beats), 2);
                chk("stall_owner", 32'(owner_id), 1);
                full = 1'b0;
            end
            tick();
        end
        req = '0;
        chk("stall_total_beats", 32'(wr_obs - w0), 4);
        tick();

        // ---------------- abandon: owner 0 drops after one beat, owner 1 waiting
        req = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            wdata_in = $urandom;
            if (m_busy != 0 && m_owner == 0 && m_beats == 1) req = 4'b0010;
            if (m_busy != 0 && m_owner == 1) break;
            tick();
        end
        chk("abandon_next_owner", 32'(owner_id), 1);
        chk("abandon_next_busy", 32'(busy), 1);
        tick();
        req = '0;
        tick(); tick();

        // ---------------- randomized traffic
        for (int c = 0; c < 1500; c++) begin
            req      = 4'($urandom);
            last     = 4'($urandom);
            full     = ($urandom_range(0, 3) == 0);
            wdata_in = $urandom;
            tick();
        end
        req = '0; last = '0; full = 1'b0;
        tick(); tick();

        // ---------------- FIFO of depth 8 filling with no reads, 2 streamers
        base = wr_obs; fifo_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            full     = (fifo_cnt >= 8);
            req      = 4'b0011;
            last     = 4'($urandom) & 4'b0011;
            wdata_in = $urandom;
            tick();
            fifo_cnt = wr_obs - base;
        end
        chk("fifo_total_writes", 32'(wr_obs - base), 8);
        req = '0; full = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
